// File: rtl/sm_mem_arbiter.sv
// sm_mem_arbiter: shares one synchronous single-port data RAM between the CPU
// load/store port and the debug/loader port; one single-word access per 4 cycles.
// Latency: request sampled in IDLE (N) -> mem_en in N+1 -> ack (and read data) in N+3.
// Backpressure: a losing request simply stays pending (req held) and is re-arbitrated next IDLE.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cpu_* / dbg_*            req/ack requester ports (we, addr, wdata in; ack, rdata out)
//   mem_en/we/addr/wdata     registered memory command, mem_rdata valid the cycle after mem_en
//
// Build option: define SM_MEM_ARB_RR_EN for round-robin tie-break; otherwise the CPU
// wins every tie (fixed priority, debug may starve under continuous CPU traffic).
module sm_mem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_ack,
   output logic [DW-1:0] dbg_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

`ifdef SM_MEM_ARB_RR_EN
   localparam bit RrEn = 1'b1;
`else
   localparam bit RrEn = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t state;
   logic   ownerDbg;      // 1 = debug port owns the current transaction
   logic   cmdWe;         // latched write flag, needed after mem_we is cleared
   logic   lastGrantDbg;  // 1 = debug port was granted last
   logic   grantDbg;

   // Debug wins when alone, or on a tie only in round-robin mode when the CPU
   // was served last. With RrEn=0 the lastGrantDbg term folds away.
   assign grantDbg = dbg_req && (!cpu_req || (RrEn && !lastGrantDbg));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         ownerDbg     <= 1'b0;
         cmdWe        <= 1'b0;
         lastGrantDbg <= 1'b1;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         cpu_ack      <= 1'b0;
         dbg_ack      <= 1'b0;
         cpu_rdata    <= '0;
         dbg_rdata    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req || dbg_req) begin
                  // The memory command registers double as the latched command:
                  // addr/wdata are held until the next grant.
                  ownerDbg  <= grantDbg;
                  cmdWe     <= grantDbg ? dbg_we : cpu_we;
                  mem_en    <= 1'b1;
                  mem_we    <= grantDbg ? dbg_we : cpu_we;
                  mem_addr  <= grantDbg ? dbg_addr : cpu_addr;
                  mem_wdata <= grantDbg ? dbg_wdata : cpu_wdata;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               state  <= WAIT;
            end
            WAIT: begin
               if (!cmdWe) begin
                  if (ownerDbg) dbg_rdata <= mem_rdata;
                  else          cpu_rdata <= mem_rdata;
               end
               if (ownerDbg) dbg_ack <= 1'b1;
               else          cpu_ack <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               cpu_ack      <= 1'b0;
               dbg_ack      <= 1'b0;
               lastGrantDbg <= ownerDbg;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
